// File: rtl/input_debouncer_pkg.sv
// Shared constants for the input debouncer.
// State encoding and default qualification length.
package input_debouncer_pkg;
  typedef logic [1:0] state_t;
  localparam state_t LOW_STABLE  = 2'b00;
  localparam state_t WAIT_HIGH   = 2'b01;
  localparam state_t HIGH_STABLE = 2'b10;
  localparam state_t WAIT_LOW    = 2'b11;
  localparam int DB_COUNT_DEF = 8;
endpackage

// File: rtl/input_debouncer_if.sv
// Bundle of the debouncer pad input and its qualified outputs.
// master drives the pad level, slave is the debouncer side.
interface input_debouncer_if;
  logic Raw_In;
  logic In1_Clean;
  logic Rise_Pulse;
  logic Fall_Pulse;
  logic Busy;
  modport master (
    output Raw_In,
    input  In1_Clean, Rise_Pulse, Fall_Pulse, Busy
  );
  modport slave (
    input  Raw_In,
    output In1_Clean, Rise_Pulse, Fall_Pulse, Busy
  );
endinterface

// File: rtl/input_debouncer_sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs.
// Reusable on any single-bit level crossing into CLK.
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);
  logic r_s1;
  logic r_s2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= D;
      r_s2 <= r_s1;
    end
  end

  assign Q = r_s2;
endmodule

// File: rtl/input_debouncer.sv
// Switch debouncer: synchronize, qualify DB_COUNT stable samples,
// then emit a registered clean level plus edge strobes.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEF,
  parameter int CNT_W    = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic Raw_In,
  output logic In1_Clean,
  output logic Rise_Pulse,
  output logic Fall_Pulse,
  output logic Busy
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

  logic             w_s2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_clean;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;
  logic             w_clean;
  logic             w_rise;
  logic             w_fall;
  logic             w_busy;

  sync_2ff u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (Raw_In),
    .Q   (w_s2)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= LOW_STABLE;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_busy  <= w_busy;
    end
  end

  // cnt only advances below CNT_MAX, so it can never wrap
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      LOW_STABLE: begin
        if (w_s2) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_s2) begin
          w_state_nxt = LOW_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_MAX) begin
          w_state_nxt = HIGH_STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (!w_s2) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (w_s2) begin
          w_state_nxt = HIGH_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_MAX) begin
          w_state_nxt = LOW_STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = LOW_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are precomputed from the next state and registered
  always_comb begin
    w_clean = 1'b0;
    w_busy  = 1'b0;
    w_rise  = (r_state == WAIT_HIGH)
           && (w_state_nxt == HIGH_STABLE);
    w_fall  = (r_state == WAIT_LOW)
           && (w_state_nxt == LOW_STABLE);
    case (w_state_nxt)
      LOW_STABLE:  w_clean = 1'b0;
      WAIT_HIGH:   w_busy  = 1'b1;
      HIGH_STABLE: w_clean = 1'b1;
      WAIT_LOW: begin
        w_clean = 1'b1;
        w_busy  = 1'b1;
      end
      default: begin
        w_clean = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign In1_Clean  = r_clean;
  assign Rise_Pulse = r_rise;
  assign Fall_Pulse = r_fall;
  assign Busy       = r_busy;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DB_COUNT=8.
// Edge 1 is the first rising edge after Raw_In changes.
module tb_input_debouncer;
  logic CLK;
  logic RST;
  int   n_vec;
  int   n_err;

  input_debouncer_if u_if ();

  input_debouncer #(
    .DB_COUNT (8),
    .CNT_W    (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Raw_In     (u_if.Raw_In),
    .In1_Clean  (u_if.In1_Clean),
    .Rise_Pulse (u_if.Rise_Pulse),
    .Fall_Pulse (u_if.Fall_Pulse),
    .Busy       (u_if.Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset();
    logic [3:0] obs;
    RST = 1'b0;
    u_if.Raw_In = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge CLK); #1;
      obs = {u_if.In1_Clean, u_if.Rise_Pulse,
             u_if.Fall_Pulse, u_if.Busy};
      n_vec++;
      if (obs !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_hold c=%0d got=%b exp=0000", c, obs);
      end
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge CLK); #1;
      obs = {u_if.In1_Clean, u_if.Rise_Pulse,
             u_if.Fall_Pulse, u_if.Busy};
      n_vec++;
      if (obs !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_steady e=%0d got=%b exp=0000", e, obs);
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [3:0] obs;
    logic [3:0] exp;
    @(negedge CLK);
    u_if.Raw_In = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge CLK); #1;
      obs = {u_if.In1_Clean, u_if.Rise_Pulse,
             u_if.Fall_Pulse, u_if.Busy};
      exp = {e >= 11, e == 11, 1'b0, e >= 3 && e <= 10};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL rise e=%0d got=%b exp=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_fall();
    logic [3:0] obs;
    logic [3:0] exp;
    @(negedge CLK);
    u_if.Raw_In = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge CLK); #1;
      obs = {u_if.In1_Clean, u_if.Rise_Pulse,
             u_if.Fall_Pulse, u_if.Busy};
      exp = {e < 11, 1'b0, e == 11, e >= 3 && e <= 10};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL fall e=%0d got=%b exp=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] obs;
    logic [3:0] exp;
    for (int e = 1; e <= 20; e++) begin
      @(negedge CLK);
      u_if.Raw_In = (e <= 5);
      @(posedge CLK); #1;
      obs = {u_if.In1_Clean, u_if.Rise_Pulse,
             u_if.Fall_Pulse, u_if.Busy};
      exp = {3'b000, e >= 3 && e <= 7};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL glitch e=%0d got=%b exp=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] obs;
    logic [3:0] exp;
    @(negedge CLK);
    u_if.Raw_In = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    n_vec++;
    if (u_if.Busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_busy got=%b exp=1", u_if.Busy);
    end
    #2;
    RST = 1'b0;
    #1;
    obs = {u_if.In1_Clean, u_if.Rise_Pulse,
           u_if.Fall_Pulse, u_if.Busy};
    n_vec++;
    if (obs !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst_clear got=%b exp=0000", obs);
    end
    for (int c = 1; c <= 2; c++) begin
      @(posedge CLK); #1;
      obs = {u_if.In1_Clean, u_if.Rise_Pulse,
             u_if.Fall_Pulse, u_if.Busy};
      n_vec++;
      if (obs !== 4'b0000) begin
        n_err++;
        $display("FAIL midrst_hold c=%0d got=%b exp=0000", c, obs);
      end
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge CLK); #1;
      obs = {u_if.In1_Clean, u_if.Rise_Pulse,
             u_if.Fall_Pulse, u_if.Busy};
      exp = {e >= 11, e == 11, 1'b0, e >= 3 && e <= 10};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL midrst_rise e=%0d got=%b exp=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_bounce();
    int n_rise;
    int rise_e;
    @(negedge CLK);
    u_if.Raw_In = 1'b0;
    repeat (15) @(posedge CLK);
    n_rise = 0;
    rise_e = 0;
    for (int e = 1; e <= 35; e++) begin
      @(negedge CLK);
      if (e <= 12) u_if.Raw_In = (((e - 1) / 2) % 2) == 0;
      else         u_if.Raw_In = 1'b1;
      @(posedge CLK); #1;
      if (u_if.Rise_Pulse === 1'b1) begin
        n_rise++;
        rise_e = e;
      end
      n_vec++;
      if (u_if.In1_Clean !== (e >= 23)) begin
        n_err++;
        $display("FAIL bounce_clean e=%0d got=%b exp=%b",
                 e, u_if.In1_Clean, e >= 23);
      end
      n_vec++;
      if (u_if.Fall_Pulse !== 1'b0) begin
        n_err++;
        $display("FAIL bounce_fall e=%0d got=%b exp=0",
                 e, u_if.Fall_Pulse);
      end
    end
    n_vec++;
    if (n_rise != 1) begin
      n_err++;
      $display("FAIL bounce_nrise got=%0d exp=1", n_rise);
    end
    n_vec++;
    if (rise_e != 23) begin
      n_err++;
      $display("FAIL bounce_rise_edge got=%0d exp=23", rise_e);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    RST = 1'b0;
    u_if.Raw_In = 1'b0;
    test_reset();
    test_clean_rise();
    test_fall();
    test_glitch();
    test_mid_reset();
    test_bounce();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter DB_COUNT, default 8, meaning the number of consecutive stable synchronized samples needed to accept a level change; legal range 2..255.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the debounce counter width; SHALL satisfy 2**CNT_W >= DB_COUNT.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Raw_In, input, 1 bit: asynchronous, bouncy level from a switch or pad.
REQ-006 SHALL have port In1_Clean, output, 1 bit: registered debounced level, fed directly to the downstream sequence FSM input In1.
REQ-007 SHALL have port Rise_Pulse, output, 1 bit: registered one-cycle strobe when In1_Clean goes 0->1.
REQ-008 SHALL have port Fall_Pulse, output, 1 bit: registered one-cycle strobe when In1_Clean goes 1->0.
REQ-009 SHALL have port Busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-010 SHALL pass Raw_In through a two-flop synchronizer; only the second flop output (s2) SHALL feed the FSM.
REQ-011 SHALL implement four states: LOW_STABLE, WAIT_HIGH, HIGH_STABLE, WAIT_LOW.
REQ-012 In LOW_STABLE with s2=1, SHALL go to WAIT_HIGH with cnt=0; with s2=0, SHALL stay in LOW_STABLE.
REQ-013 In WAIT_HIGH with s2=0, SHALL return to LOW_STABLE with cnt=0 and no output change; this filters the glitch.
REQ-014 In WAIT_HIGH with s2=1 and cnt<DB_COUNT-1, SHALL increment cnt.
REQ-015 In WAIT_HIGH with s2=1 and cnt=DB_COUNT-1, SHALL go to HIGH_STABLE on that edge, set In1_Clean=1 and Rise_Pulse=1, and clear cnt.
REQ-016 WAIT_LOW / HIGH_STABLE SHALL mirror REQ-012..015 with the polarities inverted, asserting Fall_Pulse and setting In1_Clean=0.
REQ-017 Rise_Pulse and Fall_Pulse SHALL each be high for exactly one cycle and SHALL never be high together.
REQ-018 Latency: with Raw_In held stable after a change, In1_Clean SHALL update on rising edge DB_COUNT+3, counting the first edge that samples the new Raw_In as edge 1.
REQ-019 Busy SHALL be 1 exactly when the state is WAIT_HIGH or WAIT_LOW.
REQ-020 cnt SHALL saturate logically at DB_COUNT-1 and SHALL never wrap.
REQ-021 All outputs SHALL be driven from flops, with no combinational path from Raw_In to any output.
REQ-022 Every case statement SHALL have a default branch that goes to LOW_STABLE; illegal states SHALL recover within one cycle.

Reset
REQ-023 While RST=0, the block SHALL asynchronously clear: both synchronizer flops, cnt, state (to LOW_STABLE), In1_Clean, Rise_Pulse, Fall_Pulse and Busy, all to 0.
REQ-024 Reset asserted mid-qualification SHALL discard the partial count, and SHALL generate no pulse.
REQ-025 After RST deasserts with Raw_In=1, the block SHALL qualify the level as a normal rise, including a Rise_Pulse after DB_COUNT+3 edges.

Structure
REQ-026 The state encoding (2-bit localparams LOW_STABLE=00, WAIT_HIGH=01, HIGH_STABLE=10, WAIT_LOW=11) SHALL live in a shared package, together with the default DB_COUNT.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff, with ports CLK, RST, D and Q, for reuse on other pad inputs.
REQ-028 Next-state logic and state/output registers SHALL be in separate always blocks, and the sequential block SHALL use nonblocking assignments only.

Verification (DB_COUNT=8)
REQ-029 Reset then steady: RST=0 for 3 cycles, then Raw_In=0 -> all outputs 0 and Busy=0.
REQ-030 Clean rise: Raw_In 0->1 held 20 cycles -> In1_Clean=1 and Rise_Pulse=1 for one cycle at edge 11, with Busy=1 on edges 3..10.
REQ-031 Glitch filter: Raw_In=1 for 5 cycles, then 0 -> In1_Clean stays 0, no pulse, and Busy returns to 0.
REQ-032 Bounce: Raw_In toggles every 2 cycles for 12 cycles, then holds 1 -> exactly one Rise_Pulse, 11 edges after the final stable 1.
REQ-033 Fall: starting from HIGH_STABLE, Raw_In=0 held -> In1_Clean=0 and a single Fall_Pulse at edge 11.
REQ-034 Mid-qualification reset: assert RST=0 at cnt=5 in WAIT_HIGH -> outputs clear immediately and no pulse follows; after release with Raw_In=1, Rise_Pulse arrives at edge 11.
